seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked, multi-cycle ALU for the pipelined RiSC-16 execute stage and its co-processor experiments. It extends the combinational add/nand/equality datapath with subtract, xor, iterative multiply and iterative shifts. Operands are captured on a valid/ready transfer and results are held in registers until the consumer accepts them.

## Interface
- p_WORD_LEN, 16, operand/result width (≥4, power of two)
- p_SHAMT_LEN, $clog2(p_WORD_LEN), shift-count bits taken from i_inb[p_SHAMT_LEN-1:0]
- i_clk  in  1  clock; all state changes on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  request valid
- o_ready  out  1  request can be accepted this cycle
- i_op  in  3  000 ADD, 001 NAND, 010 SUB, 011 XOR, 100 MUL, 101 SHL, 110 SRL, 111 reserved
- i_ina  in  p_WORD_LEN  operand a
- i_inb  in  p_WORD_LEN  operand b / shift count
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts result this cycle
- o_out  out  p_WORD_LEN  result
- o_eq  out  1  captured i_ina == i_inb
- o_carry  out  1  ADD carry-out; SUB carry of ina+~inb+1 (1 = no borrow); MUL 1 if product bits [2W-1:W] nonzero; otherwise 0

## Operation
- States: IDLE, BUSY, DONE. Reset: state IDLE, o_valid 0, o_out 0, o_eq 0, o_carry 0, counter 0, accumulators 0.
- Accept = i_valid && o_ready. o_ready = !i_rst && (IDLE || (DONE && i_ready)). No transfer while i_rst is high.
- On accept:
  - o_eq is registered from the operands.
  - Single-cycle ops (ADD, NAND, SUB, XOR, reserved → 0, SHL/SRL with count 0 → ina) load o_out/o_carry and go to DONE.
  - MUL loads multiplicand, multiplier and a 2W accumulator, sets counter = W, and goes to BUSY.
  - SHL/SRL with count n>0 load the shift register, set counter = n, and go to BUSY.
- BUSY, one step per cycle:
  - MUL: shift-add one multiplier bit, LSB first.
  - SHL/SRL: shift one bit, zero fill.
  - Counter decrements each cycle. The step that brings the counter to 0 writes o_out/o_carry and moves to DONE.
- Arithmetic is modulo 2^W. MUL is unsigned and o_out holds the low W bits. Only i_inb[p_SHAMT_LEN-1:0] is used as the shift count; upper bits are ignored.
- DONE: o_valid=1; o_out, o_eq and o_carry are stable until i_ready.
  - i_ready without a new accept → IDLE.
  - i_ready with a new accept → start the new op in the same edge (DONE again for single-cycle ops, BUSY otherwise).
- BUSY ignores i_valid (o_ready=0). i_op, i_ina and i_inb are don't-care outside accept cycles.
- Reset mid-operation (any state): everything returns to reset values immediately and the in-flight result is discarded.

## Timing
- Latency is counted from the accept edge to the first cycle with o_valid=1:
  - Single-cycle ops and shift count 0: 1 cycle.
  - SHL/SRL with count n: n+1 cycles.
  - MUL: W+1 cycles (17 at W=16).
- Back-to-back single-cycle ops with i_ready held high: one result per cycle, o_valid continuously 1.
- A multi-cycle op accepted from DONE drops o_valid on the next cycle.
- o_ready is combinational from state, i_ready and i_rst. There is no combinational path from i_valid or operands to any output.

## Test plan
- ADD 0xFFFF+0x0001 → o_out 0x0000, o_carry 1, o_eq 0, o_valid exactly 1 cycle after accept. NAND 0xF0F0,0xFF00 → 0x0FFF, carry 0.
- SUB 0x1234−0x1234 → 0x0000, o_eq 1, o_carry 1. SUB 0x0001−0x0002 → 0xFFFF, o_carry 0. XOR 0xAAAA,0xFFFF → 0x5555.
- MUL 0x0003×0x0005 → 0x000F, carry 0, o_valid 17 cycles after accept, o_ready 0 throughout BUSY. MUL 0x0100×0x0100 → 0x0000, carry 1.
- SHL 0x0001 by 15 → 0x8000 at latency 16. SRL 0x8000 by 0 → 0x8000 at latency 1. SHL 0x0001 with i_inb=0x0013 → 0x0008 at latency 4.
- Backpressure: i_ready low for 5 cycles in DONE → o_out/o_eq/o_carry stable, o_ready 0. Then i_ready=1 with a new ADD in the same cycle → accepted, next result 1 cycle later with o_valid never dropping.
- Assert i_rst during MUL at BUSY cycle 8 → o_valid/o_out/o_carry/o_eq 0 asynchronously. After release: o_ready 1, no stale o_valid, and a new ADD completes normally.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked multi-cycle ALU: single-cycle add/nand/sub/xor, iterative
// shift-add multiply and bit-serial shifts, results held until accepted.
module seq_alu #(
    parameter int p_WORD_LEN  = 16,
    parameter int p_SHAMT_LEN = $clog2(p_WORD_LEN)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_op,
    input  logic [p_WORD_LEN-1:0] i_ina,
    input  logic [p_WORD_LEN-1:0] i_inb,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [p_WORD_LEN-1:0] o_out,
    output logic                  o_eq,
    output logic                  o_carry
);

    localparam int W  = p_WORD_LEN;
    localparam int CW = $clog2(p_WORD_LEN) + 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SRL  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [W-1:0]   r_out;
    logic           r_eq;
    logic           r_carry;
    logic [CW-1:0]  r_cnt;
    logic           r_is_mul;
    logic           r_is_left;
    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mplier;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_shift;

    logic                   w_accept;
    logic                   w_multi;
    logic                   w_last;
    logic [p_SHAMT_LEN-1:0] w_shamt;
    logic [W:0]             w_add;
    logic [W:0]             w_sub;
    logic [W-1:0]           w_nand;
    logic [W-1:0]           w_xor;
    logic [W-1:0]           w_single_out;
    logic                   w_single_carry;
    logic [2*W-1:0]         w_acc_step;
    logic [W-1:0]           w_shift_step;

    assign w_accept = i_valid && o_ready;
    assign w_shamt  = i_inb[p_SHAMT_LEN-1:0];
    assign w_last   = (r_cnt == CW'(1));
    assign w_multi  = (i_op == OP_MUL) ||
                      (((i_op == OP_SHL) || (i_op == OP_SRL)) && (w_shamt != '0));

    // Carry of ina + ~inb + 1, so 1 means no borrow.
    assign w_add = {1'b0, i_ina} + {1'b0, i_inb};
    assign w_sub = {1'b0, i_ina} + {1'b0, ~i_inb} + (W+1)'(1);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bitwise
            assign w_nand[gi] = ~(i_ina[gi] & i_inb[gi]);
            assign w_xor[gi]  = i_ina[gi] ^ i_inb[gi];
        end
    endgenerate

    always_comb begin
        w_single_out   = '0;
        w_single_carry = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_single_out   = w_add[W-1:0];
                w_single_carry = w_add[W];
            end
            OP_NAND: w_single_out = w_nand;
            OP_SUB: begin
                w_single_out   = w_sub[W-1:0];
                w_single_carry = w_sub[W];
            end
            OP_XOR: w_single_out = w_xor;
            OP_SHL,
            OP_SRL: w_single_out = i_ina;
            default: w_single_out = '0;
        endcase
    end

    assign w_acc_step   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_shift_step = r_is_left ? (r_shift << 1) : (r_shift >> 1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = w_multi ? S_BUSY : S_DONE;
        end else begin
            case (r_state)
                S_BUSY:  if (w_last) w_state_next = S_DONE;
                S_DONE:  if (i_ready) w_state_next = S_IDLE;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        o_valid = (r_state == S_DONE);
        o_ready = !i_rst && ((r_state == S_IDLE) || ((r_state == S_DONE) && i_ready));
        o_out   = r_out;
        o_eq    = r_eq;
        o_carry = r_carry;
    end

    // Accept and BUSY stepping are mutually exclusive since o_ready is low in BUSY.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out     <= '0;
            r_eq      <= 1'b0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_is_mul  <= 1'b0;
            r_is_left <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_shift   <= '0;
        end else if (w_accept) begin
            r_eq <= (i_ina == i_inb);
            if (!w_multi) begin
                r_out   <= w_single_out;
                r_carry <= w_single_carry;
            end else if (i_op == OP_MUL) begin
                r_is_mul <= 1'b1;
                r_mcand  <= {{W{1'b0}}, i_ina};
                r_mplier <= i_inb;
                r_acc    <= '0;
                r_cnt    <= CW'(W);
            end else begin
                r_is_mul  <= 1'b0;
                r_is_left <= (i_op == OP_SHL);
                r_shift   <= i_ina;
                r_cnt     <= CW'(w_shamt);
            end
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_is_mul) begin
                r_acc    <= w_acc_step;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                if (w_last) begin
                    r_out   <= w_acc_step[W-1:0];
                    r_carry <= |w_acc_step[2*W-1:W];
                end
            end else begin
                r_shift <= w_shift_step;
                if (w_last) begin
                    r_out   <= w_shift_step;
                    r_carry <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed requests push expectations, a
// monitor compares every presented result and its latency.
module tb_seq_alu;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  i_op = 3'b000;
    logic [15:0] i_ina = '0;
    logic [15:0] i_inb = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [15:0] o_out;
    logic        o_eq;
    logic        o_carry;

    typedef struct {
        logic [15:0] out;
        logic        eq;
        logic        carry;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   cur_start = -1;

    seq_alu #(.p_WORD_LEN(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_ina(i_ina), .i_inb(i_inb), .o_valid(o_valid),
        .i_ready(i_ready), .o_out(o_out), .o_eq(o_eq), .o_carry(o_carry)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compares the front expectation every cycle a result is shown.
    always @(negedge i_clk) begin
        #2;
        if (!i_rst && o_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid: o_valid=1 with no outstanding request, out=0x%0h", o_out);
            end else begin
                if (cur_start < 0) cur_start = cyc;
                check({q[0].name, "_result"}, {13'd0, o_out, o_eq, o_carry},
                      {13'd0, q[0].out, q[0].eq, q[0].carry});
                if (i_ready) begin
                    check({q[0].name, "_latency"}, cur_start - q[0].acc + 1, q[0].lat);
                    $display("txn %-10s out=0x%04h eq=%0b carry=%0b latency=%0d", q[0].name,
                             o_out, o_eq, o_carry, cur_start - q[0].acc + 1);
                    void'(q.pop_front());
                    cur_start = -1;
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] e_out, input logic e_eq, input logic e_carry,
                         input int e_lat, input string name);
        exp_t e;
        int   n;
        i_valid = 1'b1;
        i_op    = op;
        i_ina   = a;
        i_inb   = b;
        #1;
        n = 0;
        while (!o_ready && n < 200) begin
            @(negedge i_clk);
            #1;
            n++;
        end
        if (!o_ready) begin
            check({name, "_accept_timeout"}, 32'(o_ready), 32'd1);
        end else begin
            e.out = e_out; e.eq = e_eq; e.carry = e_carry;
            e.lat = e_lat; e.acc = cyc + 1; e.name = name;
            q.push_back(e);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        @(negedge i_clk);
        #3;
        check("drain_pending", q.size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        #1;
        check("reset_outputs", {28'd0, o_valid, o_out != 0, o_eq, o_carry}, 32'd0);
        check("reset_ready", 32'(o_ready), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        issue(3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1, "add_wrap");
        issue(3'b001, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0, 1'b0, 1, "nand");
        issue(3'b010, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1, 1, "sub_eq");
        issue(3'b010, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0, 1, "sub_borrow");
        issue(3'b011, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 1'b0, 1, "xor");
        issue(3'b111, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1, "reserved");
        drain();

        issue(3'b100, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 17, "mul_3x5");
        for (int i = 0; i < 16; i++) begin
            #1;
            check("mul_busy_ready", {30'd0, o_ready, o_valid}, 32'd0);
            @(negedge i_clk);
        end
        drain();
        issue(3'b100, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 17, "mul_ovf");
        drain();

        issue(3'b101, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 16, "shl_15");
        drain();
        issue(3'b110, 16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b0, 1, "srl_0");
        drain();
        issue(3'b101, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0, 4, "shl_mask");
        drain();
        issue(3'b110, 16'h8000, 16'h0004, 16'h0800, 1'b0, 1'b0, 5, "srl_4");
        drain();

        i_ready = 1'b0;
        issue(3'b000, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1, "add_stall");
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_ready", 32'(o_ready), 32'd0);
            @(negedge i_clk);
        end
        i_ready = 1'b1;
        issue(3'b000, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1, "add_chain");
        issue(3'b000, 16'h0001, 16'h0001, 16'h0002, 1'b1, 1'b0, 1, "b2b_1");
        issue(3'b000, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1, "b2b_2");
        issue(3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1, "b2b_3");
        drain();

        issue(3'b100, 16'h0007, 16'h0007, 16'h0031, 1'b1, 1'b0, 17, "mul_reset");
        repeat (7) @(negedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        check("rst_async_outputs", {28'd0, o_valid, o_out != 0, o_eq, o_carry}, 32'd0);
        q.delete();
        cur_start = -1;
        @(negedge i_clk);
        check("rst_hold_ready", 32'(o_ready), 32'd0);
        i_rst = 1'b0;
        #1;
        check("rst_release", {30'd0, o_ready, o_valid}, 32'd2);
        @(negedge i_clk);
        issue(3'b000, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1, "add_after_rst");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
